// File: rtl/bp_retire_sched.sv
// rtl/bp_retire_sched.sv - in-order retire scheduler feeding one-cycle update pulses to a gshare predictor
// Branches are tracked in a circular queue, resolved out of order, and retired in order through an IDLE/PULSE/GAP FSM.
module bp_retire_sched #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 2,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_ready,
  output logic [TAG_W-1:0]  pred_tag,
  output logic              bp_start,
  input  logic              bp_prediction,
  input  logic              res_valid,
  input  logic [TAG_W-1:0]  res_tag,
  input  logic              res_taken,
  output logic              bp_update,
  output logic [ADDR_W-1:0] bp_update_addr,
  output logic              bp_branch_taken,
  output logic              mispredict,
  output logic [TAG_W:0]    count
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]      count_q, count_d;
  logic [DEPTH-1:0]    valid_q, valid_d, resolved_q, resolved_d;
  logic [DEPTH-1:0]    pred_q, pred_d, actual_q, actual_d;
  logic [ADDR_W-1:0]   pc_q [DEPTH];
  logic [ADDR_W-1:0]   pc_d [DEPTH];
  logic                flag_q, flag_d;
  logic                bp_update_q, bp_update_d;
  logic                mispredict_q, mispredict_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                taken_q, taken_d;

  logic alloc, pop, flush, head_res, head_ready, head_actual;

  assign pred_ready      = (count_q < (TAG_W+1)'(DEPTH)) && !(state_q == PULSE && flag_q);
  assign alloc           = pred_valid && pred_ready;
  assign bp_start        = alloc;
  assign pred_tag        = tail_q;
  assign bp_update       = bp_update_q;
  assign mispredict      = mispredict_q;
  assign bp_update_addr  = addr_q;
  assign bp_branch_taken = taken_q;
  assign count           = count_q;

  // A resolve aimed at the head this cycle is forwarded so retirement starts on the next edge.
  assign head_res    = res_valid && (res_tag == head_q);
  assign head_ready  = valid_q[head_q] && (resolved_q[head_q] || head_res);
  assign head_actual = head_res ? res_taken : actual_q[head_q];

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    valid_d      = valid_q;
    resolved_d   = resolved_q;
    pred_d       = pred_q;
    actual_d     = actual_q;
    pc_d         = pc_q;
    flag_d       = flag_q;
    bp_update_d  = 1'b0;
    mispredict_d = 1'b0;
    addr_d       = addr_q;
    taken_d      = taken_q;
    pop          = 1'b0;
    flush        = 1'b0;

    if (res_valid && valid_q[res_tag]) begin
      resolved_d[res_tag] = 1'b1;
      actual_d[res_tag]   = res_taken;
    end

    if (alloc) begin
      valid_d[tail_q]    = 1'b1;
      resolved_d[tail_q] = 1'b0;
      pred_d[tail_q]     = bp_prediction;
      pc_d[tail_q]       = pred_pc;
      tail_d             = tail_q + TAG_W'(1);
    end

    case (state_q)
      IDLE, GAP: begin
        state_d = IDLE;
        if (head_ready) begin
          addr_d       = pc_q[head_q];
          taken_d      = head_actual;
          flag_d       = pred_q[head_q] != head_actual;
          bp_update_d  = 1'b1;
          mispredict_d = pred_q[head_q] != head_actual;
          state_d      = PULSE;
        end
      end
      PULSE: begin
        pop     = 1'b1;
        flush   = flag_q;
        state_d = GAP;
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + TAG_W'(1);
    end

    count_d = count_q + (TAG_W+1)'(alloc) - (TAG_W+1)'(pop);

    // Flush wins over everything: younger entries, same-cycle resolves and allocation are dropped.
    if (flush) begin
      valid_d = '0;
      tail_d  = head_q + TAG_W'(1);
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      resolved_q   <= '0;
      pred_q       <= '0;
      actual_q     <= '0;
      pc_q         <= '{default: '0};
      flag_q       <= 1'b0;
      bp_update_q  <= 1'b0;
      mispredict_q <= 1'b0;
      addr_q       <= '0;
      taken_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      resolved_q   <= resolved_d;
      pred_q       <= pred_d;
      actual_q     <= actual_d;
      pc_q         <= pc_d;
      flag_q       <= flag_d;
      bp_update_q  <= bp_update_d;
      mispredict_q <= mispredict_d;
      addr_q       <= addr_d;
      taken_q      <= taken_d;
    end
  end

endmodule

// File: tb/tb_bp_retire_sched.sv
// tb/tb_bp_retire_sched.sv - directed self-checking bench for bp_retire_sched
module tb_bp_retire_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       pred_valid;
  logic [7:0] pred_pc;
  logic       pred_ready;
  logic [1:0] pred_tag;
  logic       bp_start;
  logic       bp_prediction;
  logic       res_valid;
  logic [1:0] res_tag;
  logic       res_taken;
  logic       bp_update;
  logic [7:0] bp_update_addr;
  logic       bp_branch_taken;
  logic       mispredict;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  bp_retire_sched #(.DEPTH(4), .TAG_W(2), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_ready(pred_ready), .pred_tag(pred_tag),
    .bp_start(bp_start), .bp_prediction(bp_prediction),
    .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
    .bp_update(bp_update), .bp_update_addr(bp_update_addr), .bp_branch_taken(bp_branch_taken),
    .mispredict(mispredict), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; pred_valid = 1'b0; pred_pc = '0; bp_prediction = 1'b0;
    res_valid = 1'b0; res_tag = '0; res_taken = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic alloc(input logic [7:0] pc, input logic pred, input logic [1:0] exp_tag);
    pred_valid = 1'b1; pred_pc = pc; bp_prediction = pred;
    #1;
    chk("alloc_tag", 32'(pred_tag), 32'(exp_tag));
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic [1:0] tag, input logic taken);
    res_valid = 1'b1; res_tag = tag; res_taken = taken;
    tick();
    res_valid = 1'b0;
  endtask

  // Entered in a PULSE cycle: checks the pulse, the gap after it, and steps one more cycle.
  task automatic retire_chk(input logic [7:0] addr, input logic taken, input logic misp, input bit ready_after);
    chk("upd_high", 32'(bp_update), 32'd1);
    chk("upd_addr", 32'(bp_update_addr), 32'(addr));
    chk("upd_taken", 32'(bp_branch_taken), 32'(taken));
    chk("upd_misp", 32'(mispredict), 32'(misp));
    tick();
    chk("gap_low", 32'(bp_update), 32'd0);
    chk("gap_addr_stable", 32'(bp_update_addr), 32'(addr));
    if (ready_after) chk("ready_after_pop", 32'(pred_ready), 32'd1);
    tick();
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_update", 32'(bp_update), 32'd0);
    chk("rst_misp", 32'(mispredict), 32'd0);
    chk("rst_addr", 32'(bp_update_addr), 32'd0);
    chk("rst_ready", 32'(pred_ready), 32'd1);
    chk("rst_tag", 32'(pred_tag), 32'd0);

    // single branch, correct prediction
    pred_valid = 1'b1; pred_pc = 8'h10; bp_prediction = 1'b1;
    #1;
    chk("t1_start", 32'(bp_start), 32'd1);
    chk("t1_tag", 32'(pred_tag), 32'd0);
    tick();
    pred_valid = 1'b0;
    chk("t1_count", 32'(count), 32'd1);
    resolve(2'd0, 1'b1);
    retire_chk(8'h10, 1'b1, 1'b0, 1'b0);
    chk("t1_count_end", 32'(count), 32'd0);

    // fill, resolve out of order, retire in order
    do_reset();
    for (int i = 0; i < 4; i++) alloc(8'(32'h20 + i), i[0], 2'(i));
    chk("t2_full_ready", 32'(pred_ready), 32'd0);
    chk("t2_full_count", 32'(count), 32'd4);
    resolve(2'd3, 1'b1);
    resolve(2'd1, 1'b1);
    resolve(2'd2, 1'b0);
    chk("t2_no_early_upd", 32'(bp_update), 32'd0);
    resolve(2'd0, 1'b0);
    chk("t2_ready_in_pulse", 32'(pred_ready), 32'd0);
    retire_chk(8'h20, 1'b0, 1'b0, 1'b1);
    retire_chk(8'h21, 1'b1, 1'b0, 1'b0);
    retire_chk(8'h22, 1'b0, 1'b0, 1'b0);
    retire_chk(8'h23, 1'b1, 1'b0, 1'b0);
    chk("t2_idle_low", 32'(bp_update), 32'd0);
    chk("t2_count_end", 32'(count), 32'd0);

    // mispredict flush, with allocate and younger resolve in the flush cycle
    do_reset();
    alloc(8'h30, 1'b0, 2'd0);
    alloc(8'h31, 1'b1, 2'd1);
    alloc(8'h32, 1'b1, 2'd2);
    resolve(2'd2, 1'b1);
    resolve(2'd0, 1'b1);
    chk("t3_upd", 32'(bp_update), 32'd1);
    chk("t3_addr", 32'(bp_update_addr), 32'h30);
    chk("t3_taken", 32'(bp_branch_taken), 32'd1);
    chk("t3_misp", 32'(mispredict), 32'd1);
    pred_valid = 1'b1; pred_pc = 8'h40; bp_prediction = 1'b0;
    res_valid = 1'b1; res_tag = 2'd1; res_taken = 1'b1;
    #1;
    chk("t4_flush_ready", 32'(pred_ready), 32'd0);
    chk("t4_flush_start", 32'(bp_start), 32'd0);
    tick();
    pred_valid = 1'b0; res_valid = 1'b0;
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_upd_low", 32'(bp_update), 32'd0);
    chk("t4_misp_low", 32'(mispredict), 32'd0);
    chk("t4_ready_post", 32'(pred_ready), 32'd1);
    tick();
    resolve(2'd1, 1'b0);
    chk("t3_stale_upd", 32'(bp_update), 32'd0);
    tick();
    chk("t3_stale_upd2", 32'(bp_update), 32'd0);
    chk("t3_stale_count", 32'(count), 32'd0);
    alloc(8'h41, 1'b0, 2'd1);
    chk("t3_realloc_count", 32'(count), 32'd1);

    // reset in the middle of a pulse
    do_reset();
    alloc(8'h50, 1'b0, 2'd0);
    resolve(2'd0, 1'b1);
    chk("t5_upd", 32'(bp_update), 32'd1);
    chk("t5_misp", 32'(mispredict), 32'd1);
    rst = 1'b0;
    tick();
    chk("t5_upd_cut", 32'(bp_update), 32'd0);
    chk("t5_misp_cut", 32'(mispredict), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_addr", 32'(bp_update_addr), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_ready", 32'(pred_ready), 32'd1);
    tick();
    chk("t5_upd_after", 32'(bp_update), 32'd0);

    // full queue with a pop: allocation lands the cycle after, tail wraps to 0
    do_reset();
    for (int i = 0; i < 4; i++) alloc(8'(32'h60 + i), 1'b1, 2'(i));
    resolve(2'd0, 1'b1);
    chk("t6_pulse", 32'(bp_update), 32'd1);
    pred_valid = 1'b1; pred_pc = 8'h70; bp_prediction = 1'b0;
    #1;
    chk("t6_ready_pop", 32'(pred_ready), 32'd0);
    chk("t6_start_pop", 32'(bp_start), 32'd0);
    tick();
    chk("t6_ready_next", 32'(pred_ready), 32'd1);
    chk("t6_start_next", 32'(bp_start), 32'd1);
    chk("t6_tag_wrap", 32'(pred_tag), 32'd0);
    tick();
    pred_valid = 1'b0;
    chk("t6_count_full", 32'(count), 32'd4);
    chk("t6_tail_next", 32'(pred_tag), 32'd1);
    resolve(2'd3, 1'b1);
    resolve(2'd2, 1'b1);
    resolve(2'd0, 1'b0);
    resolve(2'd1, 1'b1);
    retire_chk(8'h61, 1'b1, 1'b0, 1'b0);
    retire_chk(8'h62, 1'b1, 1'b0, 1'b0);
    retire_chk(8'h63, 1'b1, 1'b0, 1'b0);
    retire_chk(8'h70, 1'b0, 1'b0, 1'b0);
    chk("t6_count_end", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_retire_sched.md
# bp_retire_sched

Branch-prediction retire scheduler between fetch/execute and the gshare predictor. Tracks up to DEPTH in-flight conditional branches, each with its PC low byte and predicted direction. Accepts resolutions out of order and retires them in program order. For each retired branch it drives exactly one clean update pulse into the predictor. On a wrong prediction it signals a mispredict and discards every younger in-flight branch.

## Interface

Parameters:

- DEPTH, 4, number of tracking entries; power of two, 2..16
- TAG_W, 2, tag width; must equal log2(DEPTH)
- ADDR_W, 8, branch address width; matches predictor index width

Ports:

- clk, input, 1, rising-edge clock
- rst, input, 1, synchronous active-low reset; asserted when 0 and sampled on clk
- pred_valid, input, 1, fetch presents a new branch this cycle
- pred_pc, input, ADDR_W, PC low bits of that branch
- pred_ready, output, 1, entry available; allocation occurs when pred_valid && pred_ready
- pred_tag, output, TAG_W, tag assigned to the allocating branch (the tail pointer)
- bp_start, output, 1, pred_valid && pred_ready; drives predictor start
- bp_prediction, input, 1, predictor output; sampled into the entry on allocation
- res_valid, input, 1, execute resolved a branch
- res_tag, input, TAG_W, tag of the resolved branch
- res_taken, input, 1, actual direction
- bp_update, output, 1, update strobe to predictor; one-cycle high pulse
- bp_update_addr, output, ADDR_W, PC of the retiring branch
- bp_branch_taken, output, 1, actual direction of the retiring branch
- mispredict, output, 1, one-cycle pulse; retiring branch's prediction differed from its outcome
- count, output, TAG_W+1, occupied entries

## Operation

- Storage per entry: valid, resolved, pc, pred, actual. The queue is circular with head, tail and count; pointers wrap modulo DEPTH.
- Allocate: write pc and pred (from bp_prediction), set valid, clear resolved, then tail+1 and count+1.
- Resolve: if res_valid and entry[res_tag].valid, set resolved and store actual. Otherwise ignore it; this covers stale, flushed and empty tags. A repeated resolve overwrites actual while the entry is not yet retired.
- Retire FSM states: IDLE, PULSE, GAP.
  - IDLE: if head entry is valid && resolved, latch bp_update_addr/bp_branch_taken from head, load mispredict flag = pred != actual, and go to PULSE.
  - PULSE: bp_update=1 and mispredict=flag. At the end of the cycle, pop the head (clear valid, head+1, count-1). If flag is set, also flush: clear all valid bits, set tail=head+1, count=0. Then go to GAP.
  - GAP: bp_update=0. If the new head is valid && resolved, latch it and go to PULSE. Otherwise go to IDLE.
- pred_ready = (count < DEPTH) && (state != PULSE || !flag). No allocation is accepted in the flush cycle.
- Simultaneous events:
  - Allocate, resolve and pop can all occur in one cycle. count changes by (+alloc −pop).
  - Flush overrides allocation; allocation is impossible anyway via pred_ready.
  - A resolve for a younger tag during the flush cycle is discarded.
  - Full queue with a pop in the same cycle: pred_ready stays 0 that cycle and reflects the freed entry next cycle.
- Reset (rst=0), any state: state=IDLE, head=tail=0, count=0, all valid=0, bp_update=0, mispredict=0, bp_update_addr=0, bp_branch_taken=0. pred_ready=1 once rst=1. An in-flight update pulse is cut off; the predictor is reset in parallel.

## Timing

- bp_start is combinational from pred_valid/pred_ready. bp_prediction must be valid in the same cycle.
- All other outputs are registered.
- Latency: head resolved in cycle N → bp_update high in cycle N+1 if the FSM is IDLE.
- bp_update is never high two consecutive cycles; at least one low cycle separates pulses, since the predictor updates on the rising edge of bp_update. Maximum retire rate is one branch per 2 cycles.
- bp_update_addr and bp_branch_taken are stable from the PULSE cycle through the following GAP cycle.
- mispredict coincides exactly with its bp_update pulse.
- pred_ready reflects the post-flush state (count=0) one cycle after mispredict.

## Test plan

- Reset, then allocate pc 0x10 with bp_prediction=1 (tag 0) and resolve tag 0 taken. Required: bp_update pulses one cycle later with addr 0x10, taken 1, mispredict 0, then count=0.
- Allocate 4 branches (pcs 0x20..0x23). Required: pred_ready=0. Resolve them in order 3,1,2,0, all matching their predictions. Required: updates in pc order 0x20,0x21,0x22,0x23, every pulse separated by ≥1 low cycle, pred_ready=1 after the first pop.
- Allocate 3 branches; tag 0 predicted 0, resolved 1. Required: bp_update with taken 1 and mispredict=1 in the same cycle; tags 1 and 2 are flushed; a later resolve of tag 1 produces no update; the next allocation receives tag 1.
- In the flush cycle, drive pred_valid=1 and res_valid for a younger tag. Required: pred_ready=0, no allocation, resolve ignored, count=0 afterward.
- Hold rst=0 during a PULSE cycle. Required: bp_update and mispredict go low on the next edge, count=0, pred_ready=1 after release.
- Fill the queue and, in the cycle of a pop, hold pred_valid=1. Required: allocation only on the following cycle; tail wraps from 3 to 0 correctly and the assigned tag is 0.
